// File: rtl/bound_add_pkg.sv
// Shared definitions for the boundary-add frame control path: FSM states,
// default counter widths and host counter widths.
package bound_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        PASS  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int CW_DEF      = 12;
    localparam int TW_DEF      = 17;
    localparam int FRAME_CNT_W = 16;
    localparam int DROP_CNT_W  = 8;

endpackage

// File: rtl/frame_geom_chk.sv
// Per-frame geometry checker: counts pixels per line and lines per frame and
// flags any deviation from IW x IH. Flags are sticky until the next clear.
module frame_geom_chk
    import bound_add_pkg::*;
#(
    parameter int IW = 640,
    parameter int IH = 480,
    parameter int CW = CW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din_hsync,
    input  logic hs_fall,
    input  logic vs_fall,
    input  logic clear,
    output logic err_pix,
    output logic err_line
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] IW_C    = CW'(IW);
    localparam logic [CW-1:0] IH_C    = CW'(IH);

    logic [CW-1:0] pix_reg;
    logic [CW-1:0] line_reg;
    logic          err_pix_reg;
    logic          err_line_reg;
    logic [CW-1:0] pix_inc;
    logic [CW-1:0] line_inc;
    logic [CW-1:0] line_next;

    // Saturating increments; a line ending on the frame's last cycle must be
    // included in the line count checked at vsync fall.
    assign pix_inc   = (pix_reg == CNT_MAX) ? pix_reg : pix_reg + CW'(1);
    assign line_inc  = (line_reg == CNT_MAX) ? line_reg : line_reg + CW'(1);
    assign line_next = hs_fall ? line_inc : line_reg;

    // Pixel/line counting with sticky mismatch flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_reg      <= '0;
            line_reg     <= '0;
            err_pix_reg  <= 1'b0;
            err_line_reg <= 1'b0;
        end else if (clear) begin
            pix_reg      <= '0;
            line_reg     <= '0;
            err_pix_reg  <= 1'b0;
            err_line_reg <= 1'b0;
        end else begin
            if (hs_fall) begin
                if (pix_reg != IW_C) begin
                    err_pix_reg <= 1'b1;
                end
                line_reg <= line_inc;
                pix_reg  <= '0;
            end else if (din_hsync) begin
                pix_reg <= pix_inc;
            end
            if (vs_fall && (line_next != IH_C)) begin
                err_line_reg <= 1'b1;
            end
        end
    end

    assign err_pix  = err_pix_reg;
    assign err_line = err_line_reg;

endmodule

// File: rtl/bound_add_frame_ctrl.sv
// Frame-level sequencer ahead of the boundary-add pipeline: admits whole
// frames only, keeps a new frame out until the previous one has drained,
// and reports per-frame status plus admitted/dropped frame counters.
module bound_add_frame_ctrl
    import bound_add_pkg::*;
#(
    parameter int DW            = 8,
    parameter int IW            = 640,
    parameter int IH            = 480,
    parameter int CW            = CW_DEF,
    parameter int DRAIN_TIMEOUT = 65536,
    parameter int TW            = TW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_en,
    input  logic                   din_vsync,
    input  logic                   din_hsync,
    input  logic [DW-1:0]          din,
    output logic                   pipe_vsync,
    output logic                   pipe_hsync,
    output logic [DW-1:0]          pipe_din,
    input  logic                   pipe_out_vsync,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_ok,
    output logic                   err_pix,
    output logic                   err_line,
    output logic                   err_timeout,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    localparam logic [TW-1:0] TIMER_LAST = TW'(DRAIN_TIMEOUT - 1);

    state_t                 state_reg;
    logic                   vs_d_reg;
    logic                   hs_d_reg;
    logic                   pipe_vsync_reg;
    logic                   pipe_hsync_reg;
    logic [DW-1:0]          pipe_din_reg;
    logic                   seen_out_reg;
    logic [TW-1:0]          timer_reg;
    logic                   err_timeout_reg;
    logic                   frame_done_reg;
    logic                   frame_ok_reg;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg;
    logic [DROP_CNT_W-1:0]  drop_cnt_reg;

    logic vs_rise;
    logic vs_fall;
    logic hs_fall;
    logic in_pass;
    logic admit;
    logic fwd;
    logic timeout_hit;
    logic drain_done;

    assign vs_rise = din_vsync & ~vs_d_reg;
    assign vs_fall = ~din_vsync & vs_d_reg;
    assign hs_fall = ~din_hsync & hs_d_reg;

    assign in_pass     = (state_reg == PASS);
    assign admit       = (state_reg == ARM) & vs_rise & ~pipe_out_vsync;
    assign fwd         = in_pass | admit;
    assign timeout_hit = (timer_reg == TIMER_LAST);
    assign drain_done  = (seen_out_reg & ~pipe_out_vsync) | timeout_hit;

    // One-cycle-delayed sync copies used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d_reg <= 1'b0;
            hs_d_reg <= 1'b0;
        end else begin
            vs_d_reg <= din_vsync;
            hs_d_reg <= din_hsync;
        end
    end

    // Gated forwarding into the pipeline: exactly one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vsync_reg <= 1'b0;
            pipe_hsync_reg <= 1'b0;
            pipe_din_reg   <= '0;
        end else if (fwd) begin
            pipe_vsync_reg <= din_vsync;
            pipe_hsync_reg <= din_hsync;
            pipe_din_reg   <= din;
        end else begin
            pipe_vsync_reg <= 1'b0;
            pipe_hsync_reg <= 1'b0;
            pipe_din_reg   <= '0;
        end
    end

    // Geometry checks only see activity of the admitted frame.
    frame_geom_chk #(
        .IW (IW),
        .IH (IH),
        .CW (CW)
    ) u_geom (
        .clk       (clk),
        .rst       (rst),
        .din_hsync (din_hsync & in_pass),
        .hs_fall   (hs_fall & in_pass),
        .vs_fall   (vs_fall & in_pass),
        .clear     (admit),
        .err_pix   (err_pix),
        .err_line  (err_line)
    );

    // Frame sequencer: admission, drop counting, drain tracking and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            seen_out_reg    <= 1'b0;
            timer_reg       <= '0;
            err_timeout_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_ok_reg    <= 1'b0;
            frame_cnt_reg   <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            frame_ok_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cfg_en && !din_vsync) begin
                        state_reg <= ARM;
                    end
                end
                ARM: begin
                    if (!cfg_en) begin
                        state_reg <= IDLE;
                    end else if (vs_rise) begin
                        if (!pipe_out_vsync) begin
                            state_reg       <= PASS;
                            seen_out_reg    <= 1'b0;
                            timer_reg       <= '0;
                            err_timeout_reg <= 1'b0;
                        end else if (drop_cnt_reg != '1) begin
                            drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
                        end
                    end
                end
                PASS: begin
                    if (vs_fall) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_out_vsync) begin
                        seen_out_reg <= 1'b1;
                    end
                    if (drain_done) begin
                        frame_done_reg <= 1'b1;
                        frame_ok_reg   <= ~(err_pix | err_line | err_timeout_reg | timeout_hit);
                        if (timeout_hit) begin
                            err_timeout_reg <= 1'b1;
                        end
                        frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
                        state_reg     <= cfg_en ? ARM : IDLE;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pipe_vsync  = pipe_vsync_reg;
    assign pipe_hsync  = pipe_hsync_reg;
    assign pipe_din    = pipe_din_reg;
    assign busy        = (state_reg == PASS) | (state_reg == DRAIN);
    assign frame_done  = frame_done_reg;
    assign frame_ok    = frame_ok_reg;
    assign err_timeout = err_timeout_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign drop_cnt    = drop_cnt_reg;

endmodule

// File: doc/bound_add_frame_ctrl.md
Name: bound_add_frame_ctrl

Overview:
- Frame-level sequencer in front of bound_add_top in the Sobel edge-detect chain.
- Admits only whole frames into the boundary-add pipeline; never starts mid-frame; never overlaps a new frame with the previous frame's drain, i.e. the extra rows emitted during the front porch.
- Checks input geometry against IW/IH and reports per-frame status and counters for the host.

Parameters:
DW, 'd8, pixel data width
IW, 'd640, expected active pixels per line
IH, 'd480, expected active lines per frame
CW, 'd12, pixel/line counter width (2^CW-1 >= max(IW,IH)+1)
DRAIN_TIMEOUT, 'd65536, max cycles in DRAIN before timeout error
TW, 'd17, drain timer width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_en  in  1  host enable; sampled only at frame boundaries
din_vsync  in  1  camera field valid
din_hsync  in  1  camera line valid
din  in  DW  camera pixel
pipe_vsync  out  1  gated field valid to bound_add_top.din_vsync
pipe_hsync  out  1  gated line valid to bound_add_top.din_hsync
pipe_din  out  DW  gated pixel to bound_add_top.din
pipe_out_vsync  in  1  bound_add_top.dout_vsync feedback
busy  out  1  state is PASS or DRAIN
frame_done  out  1  one-cycle pulse at end of DRAIN
frame_ok  out  1  valid with frame_done: no pix/line/timeout error
err_pix  out  1  a line width != IW in last admitted frame (sticky)
err_line  out  1  line count != IH in last admitted frame (sticky)
err_timeout  out  1  drain timed out (sticky)
frame_cnt  out  16  admitted frames, wraps
drop_cnt  out  8  frames skipped while pipeline busy, saturates at 255

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; edge-detect registers 0.
- vs_rise/vs_fall/hs_fall come from a 1-cycle-delayed copy of din_vsync/din_hsync.
- Gate term: fwd = (state==PASS) | (state==ARM & vs_rise & !pipe_out_vsync).
- Forwarding: pipe_* <= fwd ? {din_vsync,din_hsync,din} : 0. Latency is exactly 1 cycle, with no other transformation.

States:
- IDLE: if cfg_en & !din_vsync -> ARM. Waiting for vsync low guarantees no partial frame after reset or enable.
- ARM:
  - !cfg_en -> IDLE.
  - vs_rise & !pipe_out_vsync -> PASS. The rising sample is forwarded. Clear err_*, counters and seen_out.
  - vs_rise & pipe_out_vsync -> frame dropped. drop_cnt+1 (saturating); stay ARM.
- PASS:
  - Count pixels while din_hsync=1 (saturate at 2^CW-1).
  - On hs_fall: if pix!=IW set err_pix; line+1 (saturate); pix<=0.
  - On vs_fall: if line!=IH set err_line; -> DRAIN. The vs-low sample is forwarded, then gating closes.
  - cfg_en is ignored in PASS; the frame always completes.
- DRAIN:
  - Set seen_out when pipe_out_vsync=1.
  - Drain timer counts from 0.
  - Done when seen_out & !pipe_out_vsync, or timer==DRAIN_TIMEOUT-1 (set err_timeout).
  - On done: frame_done=1 for 1 cycle; frame_ok = !(err_pix|err_line|err_timeout); frame_cnt+1 (wrap); -> ARM if cfg_en else IDLE.
  - din activity during DRAIN is not forwarded. A vsync rise here is not counted as a drop.
- Simultaneous hs_fall and vs_fall: line check uses the incremented count.
- Error flags hold until the next PASS entry.
- One-hot or binary state encoding is acceptable. No combinational path from input to output.

Decomposition:
- Shared package bound_add_pkg holds:
  - state localparams IDLE/ARM/PASS/DRAIN
  - CW and TW defaults
  - FRAME_CNT_W=16 and DROP_CNT_W=8
- One sub-module: frame_geom_chk.
  - Inputs: din_hsync, hs_fall, vs_fall, clear.
  - Contains the pix/line counters and compare logic; outputs err_pix and err_line.
  - Reused later by the left/right and Sobel stages.

Test Plan:
1. IW=8, IH=4; cfg_en=1; one clean frame -> pipe_* equals din delayed 1 cycle; frame_done once after pipe_out_vsync falls; frame_ok=1; frame_cnt=1.
2. Reset released while din_vsync=1 mid-frame -> pipe_vsync stays 0 for that frame; the next frame is admitted; frame_cnt=1.
3. Line 2 has 7 pixels -> err_pix=1, frame_ok=0 at frame_done; next clean frame clears err_pix, frame_ok=1.
4. Frame with 3 lines -> err_line=1. Frame with 5 lines -> err_line=1.
5. Hold pipe_out_vsync=1 when the next vsync rises in ARM -> frame not forwarded, drop_cnt=1. After 256 such drops, drop_cnt=255.
6. pipe_out_vsync never toggles, DRAIN_TIMEOUT=16 -> frame_done 16 cycles after DRAIN entry with err_timeout=1. Separately, cfg_en dropped mid-PASS -> frame completes, then state returns to IDLE and busy=0.
